// File: rtl/infrastructure_pkg.sv
// Shared types and width helpers for the clock/IDELAYCTRL infrastructure block.
package infrastructure_pkg;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_WAIT = 2'd1,
    S_OK   = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  localparam int DEF_WIN_BITS    = 10;
  localparam int DEF_RDY_TIMEOUT = 4096;
  localparam int RETRY_W         = 2;

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/infrastructure_ctrl_clk_edge_counter.sv
// One monitored clock: synchronise its divide-by-2 tick, detect either
// transition and count transitions per window, saturating at all-ones.
module clk_edge_counter
  import infrastructure_pkg::*;
#(
  parameter int WIN_BITS = DEF_WIN_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                clr,
  output logic [WIN_BITS-1:0] count
);

  logic tick_p0, tick_p1, tick_p2;
  logic chg_p2;

  // Two synchroniser flops, then a third flop kept only for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
    end else begin
      tick_p0 <= tick;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
    end
  end

  assign chg_p2 = tick_p1 ^ tick_p2;

  // Saturating edge count; a change seen on the clearing cycle starts the new window at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= WIN_BITS'(chg_p2);
    end else if (chg_p2 && !(&count)) begin
      count <= count + WIN_BITS'(1);
    end
  end

endmodule

// File: rtl/infrastructure_ctrl.sv
// Board infrastructure controller: sequences the IDELAYCTRL reset with
// timeout/retry, measures auxiliary clocks against sys_clk and holds the
// downstream reset until the delay controller and required clocks are good.
module infrastructure_ctrl
  import infrastructure_pkg::*;
#(
  parameter int NUM_CLK     = 2,
  parameter int WIN_BITS    = DEF_WIN_BITS,
  parameter int MIN_EDGES   = 64,
  parameter int RST_CYCLES  = 16,
  parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT,
  parameter int MAX_RETRY   = 3
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [NUM_CLK-1:0]          clk_tick,
  input  logic [NUM_CLK-1:0]          clk_req_mask,
  input  logic                        rearm,
  input  logic                        idelay_rdy,
  output logic                        idelay_rst,
  output logic                        dly_ok,
  output logic                        dly_fail,
  output logic [RETRY_W-1:0]          retry_cnt,
  output logic [NUM_CLK*WIN_BITS-1:0] clk_count,
  output logic [NUM_CLK-1:0]          clk_alive,
  output logic                        count_valid,
  output logic                        infra_rst
);

  localparam int TO_W = cnt_w(RDY_TIMEOUT);
  localparam int PL_W = cnt_w(RST_CYCLES);

  state_t                      state, state_nxt;
  logic [PL_W-1:0]             pulse_cnt, pulse_nxt;
  logic [TO_W-1:0]             to_cnt, to_nxt;
  logic [RETRY_W-1:0]          retry_nxt;
  logic                        rdy_p0, rdy_p1;
  logic [WIN_BITS-1:0]         win_cnt;
  logic                        win_end;
  logic [NUM_CLK*WIN_BITS-1:0] edge_cnt;
  logic [NUM_CLK-1:0]          alive_nxt;
  logic                        seen_valid;
  logic                        clk_ok;
  logic                        retry_left;

  for (genvar i = 0; i < NUM_CLK; i++) begin : g_clk
    clk_edge_counter #(.WIN_BITS(WIN_BITS)) u_cnt (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .tick  (clk_tick[i]),
      .clr   (win_end),
      .count (edge_cnt[i*WIN_BITS +: WIN_BITS])
    );
  end

  // Two-flop synchroniser for the asynchronous IDELAYCTRL ready flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdy_p0 <= 1'b0;
      rdy_p1 <= 1'b0;
    end else begin
      rdy_p0 <= idelay_rdy;
      rdy_p1 <= rdy_p0;
    end
  end

  assign win_end = &win_cnt;

  // Alive decision for each clock from the count about to be latched
  always_comb begin
    alive_nxt = '0;
    for (int i = 0; i < NUM_CLK; i++) begin
      alive_nxt[i] = edge_cnt[i*WIN_BITS +: WIN_BITS] >= WIN_BITS'(MIN_EDGES);
    end
  end

  // Free-running gate window; latch the counts on its terminal cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      win_cnt     <= '0;
      clk_count   <= '0;
      clk_alive   <= '0;
      count_valid <= 1'b0;
      seen_valid  <= 1'b0;
    end else begin
      win_cnt     <= win_cnt + WIN_BITS'(1);
      count_valid <= win_end;
      if (count_valid) seen_valid <= 1'b1;
      if (win_end) begin
        clk_count <= edge_cnt;
        clk_alive <= alive_nxt;
      end
    end
  end

  assign retry_left = retry_cnt < RETRY_W'(MAX_RETRY);

  // Delay-controller sequencer: next state, pulse/timeout counters and retries
  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_cnt;
    to_nxt    = to_cnt;
    retry_nxt = retry_cnt;
    case (state)
      S_RST: begin
        to_nxt = '0;
        if (pulse_cnt == PL_W'(RST_CYCLES - 1)) begin
          state_nxt = S_WAIT;
          pulse_nxt = '0;
        end else begin
          pulse_nxt = pulse_cnt + PL_W'(1);
        end
      end
      S_WAIT: begin
        if (rdy_p1) begin
          state_nxt = S_OK;
          to_nxt    = '0;
        end else if (to_cnt == TO_W'(RDY_TIMEOUT - 1)) begin
          to_nxt = '0;
          if (retry_left) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = S_RST;
          end else begin
            state_nxt = S_FAIL;
          end
        end else begin
          to_nxt = to_cnt + TO_W'(1);
        end
      end
      S_OK: begin
        if (!rdy_p1) begin
          if (retry_left) begin
            retry_nxt = retry_cnt + RETRY_W'(1);
            state_nxt = S_RST;
          end else begin
            state_nxt = S_FAIL;
          end
        end
      end
      S_FAIL: begin
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_RST;
        pulse_nxt = '0;
      end
    endcase
    if (rearm) begin
      state_nxt = S_RST;
      pulse_nxt = '0;
      to_nxt    = '0;
      retry_nxt = '0;
    end
  end

  // Sequencer state register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_RST;
      pulse_cnt <= '0;
      to_cnt    <= '0;
      retry_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pulse_cnt <= pulse_nxt;
      to_cnt    <= to_nxt;
      retry_cnt <= retry_nxt;
    end
  end

  assign idelay_rst = (state == S_RST);
  assign dly_ok     = (state == S_OK) && rdy_p1;
  assign dly_fail   = (state == S_FAIL);
  assign clk_ok     = &(clk_alive | ~clk_req_mask);

  // Downstream reset releases only when delay control, a measurement and required clocks are good
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      infra_rst <= 1'b1;
    end else begin
      infra_rst <= rearm || !(dly_ok && (seen_valid || count_valid) && clk_ok);
    end
  end

endmodule

// File: tb/tb_infrastructure_ctrl.sv
// Bench for infrastructure_ctrl: randomised aux-clock ticks scored per window
// against an edge-timestamp model, plus timed sequencer/reset scenarios.
module tb_infrastructure_ctrl;

  localparam int NUM_CLK  = 2;
  localparam int WIN_BITS = 10;
  localparam int WIN      = 1 << WIN_BITS;
  localparam int MAXCNT   = WIN - 1;
  localparam int MIN_E    = 64;
  localparam int RSTC     = 16;
  localparam int TOUT     = 4096;

  logic                        clk = 1'b0;
  logic                        sys_rst;
  wire  [NUM_CLK-1:0]          clk_tick;
  logic [NUM_CLK-1:0]          clk_req_mask;
  logic                        rearm;
  logic                        idelay_rdy;
  logic                        idelay_rst, dly_ok, dly_fail, count_valid, infra_rst;
  logic [1:0]                  retry_cnt;
  logic [NUM_CLK*WIN_BITS-1:0] clk_count;
  logic [NUM_CLK-1:0]          clk_alive;

  infrastructure_ctrl #(
    .NUM_CLK(NUM_CLK), .WIN_BITS(WIN_BITS), .MIN_EDGES(MIN_E),
    .RST_CYCLES(RSTC), .RDY_TIMEOUT(TOUT), .MAX_RETRY(3)
  ) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .clk_tick(clk_tick), .clk_req_mask(clk_req_mask),
    .rearm(rearm), .idelay_rdy(idelay_rdy), .idelay_rst(idelay_rst), .dly_ok(dly_ok),
    .dly_fail(dly_fail), .retry_cnt(retry_cnt), .clk_count(clk_count), .clk_alive(clk_alive),
    .count_valid(count_valid), .infra_rst(infra_rst)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int r_anchor = 0;
  bit model_on = 1'b0;
  int half[NUM_CLK];
  int exp_cnt[int];
  logic [NUM_CLK*WIN_BITS-1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A tick change driven after posedge n is first counted at posedge n+3.
  // Window 0 covers count edges [R, R+WIN-2]; later windows are WIN edges long.
  function automatic void record(input int i, input int n);
    int e, k, key;
    if (!model_on) return;
    e = n + 3;
    k = (e - r_anchor < WIN - 1) ? 0 : 1 + (e - r_anchor - (WIN - 1)) / WIN;
    key = k * NUM_CLK + i;
    if (exp_cnt.exists(key)) exp_cnt[key] = exp_cnt[key] + 1;
    else exp_cnt[key] = 1;
  endfunction

  for (genvar g = 0; g < NUM_CLK; g++) begin : g_drv
    logic tick_v = 1'b0;
    int   ph = 0;
    assign clk_tick[g] = tick_v;
    always @(posedge clk) begin
      #1;
      if (half[g] == 0) begin
        ph = 0;
        if (tick_v) begin
          tick_v = 1'b0;
          record(g, cyc);
        end
      end else begin
        ph++;
        if (ph >= half[g]) begin
          ph = 0;
          tick_v = ~tick_v;
          record(g, cyc);
        end
      end
    end
  end

  // Cycle counter and window-close predictor: push the expected counts when a window latches
  always @(posedge clk) begin
    int k, c, key;
    logic [NUM_CLK*WIN_BITS-1:0] v;
    cyc++;
    if (model_on && (cyc - r_anchor) >= WIN - 1 && ((cyc - r_anchor - (WIN - 1)) % WIN) == 0) begin
      k = (cyc - r_anchor - (WIN - 1)) / WIN;
      v = '0;
      for (int i = 0; i < NUM_CLK; i++) begin
        key = k * NUM_CLK + i;
        c = exp_cnt.exists(key) ? exp_cnt[key] : 0;
        if (c > MAXCNT) c = MAXCNT;
        v[i*WIN_BITS +: WIN_BITS] = WIN_BITS'(c);
      end
      chk("window_result_consumed", exp_q.size(), 0);
      exp_q.push_back(v);
    end
  end

  // Monitor: every count_valid pulse is scored against the oldest predicted window
  always @(negedge clk) begin
    logic [NUM_CLK*WIN_BITS-1:0] v;
    int e;
    if (count_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL count_valid_unexpected: got pulse, expected none (cycle %0d)", cyc);
      end else begin
        v = exp_q.pop_front();
        for (int i = 0; i < NUM_CLK; i++) begin
          e = int'(v[i*WIN_BITS +: WIN_BITS]);
          chk($sformatf("clk_count[%0d]", i), int'(clk_count[i*WIN_BITS +: WIN_BITS]), e);
          chk($sformatf("clk_alive[%0d]", i), int'(clk_alive[i]), (e >= MIN_E) ? 1 : 0);
        end
      end
    end
  end

  function automatic logic sig(input int s);
    case (s)
      0: return idelay_rst;
      1: return dly_ok;
      2: return dly_fail;
      3: return infra_rst;
      default: return count_valid;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for(input string name, input int s, input logic v, input int budget);
    int n = 0;
    while (sig(s) !== v && n < budget) begin
      step();
      n++;
    end
    chk(name, int'(sig(s) === v), 1);
  endtask

  task automatic pulse_len(input string name);
    int n = 0;
    while (idelay_rst === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(name, n, RSTC);
  endtask

  task automatic pulse_rearm();
    rearm = 1'b1;
    step();
    rearm = 1'b0;
  endtask

  task automatic wait_cv(input string name);
    wait_for(name, 4, 1'b1, WIN + 20);
  endtask

  task automatic do_reset(input logic with_rearm);
    sys_rst = 1'b1;
    rearm   = with_rearm;
    step();
    model_on = 1'b0;
    exp_q.delete();
    exp_cnt.delete();
    repeat (4) step();
    chk("rst_idelay_rst", int'(idelay_rst), 1);
    chk("rst_dly_ok", int'(dly_ok), 0);
    chk("rst_dly_fail", int'(dly_fail), 0);
    chk("rst_retry_cnt", int'(retry_cnt), 0);
    chk("rst_clk_count", int'(clk_count), 0);
    chk("rst_clk_alive", int'(clk_alive), 0);
    chk("rst_count_valid", int'(count_valid), 0);
    chk("rst_infra_rst", int'(infra_rst), 1);
    sys_rst  = 1'b0;
    rearm    = 1'b0;
    r_anchor = cyc + 1;
    model_on = 1'b1;
    pulse_len("rst_pulse_len");
    wait_for("dly_ok_after_pulse", 1, 1'b1, 3);
  endtask

  initial begin
    int n;
    sys_rst = 1'b1;
    rearm = 1'b0;
    idelay_rdy = 1'b1;
    clk_req_mask = 2'b01;
    for (int i = 0; i < NUM_CLK; i++) half[i] = 0;

    // Power-up with rdy already high; clock 0 toggles every 4 cycles, clock 1 dead
    do_reset(1'b0);
    chk("retry_after_boot", int'(retry_cnt), 0);
    half[0] = 4;
    wait_cv("first_count_valid");
    chk("infra_rst_before_first_cv", int'(infra_rst), 1);
    step();
    chk("infra_rst_release", int'(infra_rst), 0);
    clk_req_mask = 2'b11;
    step();
    chk("infra_rst_mask_dead_clk", int'(infra_rst), 1);
    clk_req_mask = 2'b01;
    step();
    chk("infra_rst_mask_restored", int'(infra_rst), 0);
    half[1] = int'($urandom_range(2, 12));
    repeat (int'($urandom_range(0, 40))) step();

    // One-cycle rdy drop while ready
    idelay_rdy = 1'b0;
    step();
    idelay_rdy = 1'b1;
    wait_for("dly_ok_drop", 1, 1'b0, 4);
    wait_for("retry_pulse_start", 0, 1'b1, 3);
    chk("retry_cnt_after_drop", int'(retry_cnt), 1);
    chk("infra_rst_after_drop", int'(infra_rst), 1);
    pulse_len("retry_pulse_len");
    wait_for("dly_ok_recover", 1, 1'b1, 3);
    wait_for("infra_rst_recover", 3, 1'b0, 3);

    // Rdy never arrives: rearm, then four pulses and timeouts, then failure
    idelay_rdy = 1'b0;
    pulse_rearm();
    chk("rearm_retry_cnt", int'(retry_cnt), 0);
    chk("rearm_idelay_rst", int'(idelay_rst), 1);
    chk("rearm_infra_rst", int'(infra_rst), 1);
    for (int r = 0; r < 4; r++) begin
      pulse_len($sformatf("timeout_pulse_len[%0d]", r));
      n = 0;
      while (idelay_rst === 1'b0 && dly_fail === 1'b0 && n < TOUT + 50) begin
        n++;
        step();
      end
      chk($sformatf("timeout_wait_len[%0d]", r), n, TOUT);
      if (r < 3) begin
        chk($sformatf("timeout_retry_cnt[%0d]", r), int'(retry_cnt), r + 1);
        chk($sformatf("timeout_repulse[%0d]", r), int'(idelay_rst), 1);
      end
    end
    repeat (20) step();
    chk("fail_dly_fail", int'(dly_fail), 1);
    chk("fail_idelay_rst", int'(idelay_rst), 0);
    chk("fail_retry_cnt", int'(retry_cnt), 3);
    chk("fail_infra_rst", int'(infra_rst), 1);

    // Rearm out of failure, and rearm again mid-pulse to restart the count
    idelay_rdy = 1'b1;
    pulse_rearm();
    chk("rearm2_retry_cnt", int'(retry_cnt), 0);
    chk("rearm2_dly_fail", int'(dly_fail), 0);
    repeat (5) step();
    pulse_rearm();
    pulse_len("rearm_restart_pulse_len");
    wait_for("dly_ok_after_rearm", 1, 1'b1, 3);

    // Tick every cycle: the edge counter must saturate rather than wrap
    half[0] = 1;
    for (int w = 0; w < 3; w++) begin
      wait_cv($sformatf("sat_cv[%0d]", w));
      if (w == 2) chk("sat_count0", int'(clk_count[WIN_BITS-1:0]), MAXCNT);
      step();
    end

    // Stop all ticks: counts fall to zero and the downstream reset re-asserts
    half[0] = 0;
    half[1] = 0;
    for (int w = 0; w < 2; w++) begin
      wait_cv($sformatf("dead_cv[%0d]", w));
      if (w == 1) begin
        chk("dead_count", int'(clk_count), 0);
        chk("dead_alive", int'(clk_alive), 0);
      end
      step();
    end
    chk("dead_infra_rst", int'(infra_rst), 1);

    // Consume a retry, then apply rearm together with sys_rst
    idelay_rdy = 1'b0;
    step();
    idelay_rdy = 1'b1;
    wait_for("pre_reset_retry_pulse", 0, 1'b1, 6);
    chk("pre_reset_retry_cnt", int'(retry_cnt), 1);
    do_reset(1'b1);
    clk_req_mask = 2'b11;
    half[0] = int'($urandom_range(1, 12));
    half[1] = int'($urandom_range(1, 12));
    for (int w = 0; w < 2; w++) begin
      wait_cv($sformatf("final_cv[%0d]", w));
      step();
    end
    chk("final_infra_rst", int'(infra_rst), 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/infrastructure_ctrl.md
Name: infrastructure_ctrl

Overview:
- Parametrised successor to the board clock/IDELAYCTRL infrastructure.
- Sequences the IDELAYCTRL reset, waits for its ready flag with a timeout, and retries a bounded number of times.
- Measures NUM_CLK auxiliary clocks against sys_clk and reports whether each one is alive.
- Holds a downstream infrastructure reset until the delay controller is ready and every required clock is present. Sits beside the clock buffers, ahead of all user logic.

Parameters:
NUM_CLK, 2, number of monitored auxiliary clocks
WIN_BITS, 10, gate window is 2^WIN_BITS sys_clk cycles; also width of each edge count
MIN_EDGES, 64, minimum edges per window for a clock to count as alive
RST_CYCLES, 16, IDELAYCTRL reset pulse length in sys_clk cycles (>=1)
RDY_TIMEOUT, 4096, cycles to wait for idelay_rdy before a retry
MAX_RETRY, 3, retries before declaring failure; retry_cnt width is 2 bits

Ports:
sys_clk  in  1  the single clock; all logic on rising edge
sys_rst  in  1  synchronous, active-high reset
clk_tick  in  NUM_CLK  per-clock toggle (divide-by-2) generated in each aux domain; asynchronous
clk_req_mask  in  NUM_CLK  1 = clock i must be alive before infra_rst releases (quasi-static)
rearm  in  1  single-cycle request to restart the IDELAYCTRL sequence
idelay_rdy  in  1  IDELAYCTRL RDY; asynchronous
idelay_rst  out  1  IDELAYCTRL RST
dly_ok  out  1  delay controller ready
dly_fail  out  1  retries exhausted
retry_cnt  out  2  retries consumed; saturates at MAX_RETRY
clk_count  out  NUM_CLK*WIN_BITS  last window edge count per clock; clock i occupies bits [i*WIN_BITS +: WIN_BITS]
clk_alive  out  NUM_CLK  last window count >= MIN_EDGES
count_valid  out  1  one-cycle pulse when clk_count and clk_alive update
infra_rst  out  1  downstream reset, active-high

Behaviour:
- Reset values (sys_rst high):
  - idelay_rst=1, dly_ok=0, dly_fail=0, retry_cnt=0.
  - clk_count=0, clk_alive=0, count_valid=0, infra_rst=1.
  - FSM in S_RST with pulse counter 0; window counter 0.
- Synchronisers: clk_tick[i] and idelay_rdy each pass through 2 flops. clk_tick also gets a third flop for edge detect.
- Edge counting: an edge is any change of synchronised tick (rise or fall). Latency from tick change to counting is 3 cycles.
- Window:
  - The window counter runs freely from 0 to 2^WIN_BITS-1.
  - On the terminal cycle, the per-clock edge counters are latched into clk_count and clk_alive is updated. count_valid is 1 in the following cycle only, aligned with the new values.
  - Edge counters then clear. An edge detected on the terminal cycle is counted in the new window.
  - Edge counters saturate at all-ones and do not wrap.
- FSM:
  - S_RST: idelay_rst=1; count RST_CYCLES cycles; go to S_WAIT.
  - S_WAIT: idelay_rst=0; timeout counter runs.
    - rdy_s=1 -> S_OK.
    - Timeout reached with retry_cnt<MAX_RETRY -> retry_cnt+1, S_RST.
    - Timeout reached with retry_cnt==MAX_RETRY -> S_FAIL.
  - S_OK: dly_ok=1. If rdy_s drops: dly_ok=0; if retry_cnt<MAX_RETRY -> retry_cnt+1, S_RST; else -> S_FAIL.
  - S_FAIL: dly_fail=1, idelay_rst=0; leave only on rearm or sys_rst.
  - rearm in any state: retry_cnt=0, dly_ok=0, dly_fail=0, next state S_RST. sys_rst overrides rearm. rearm during S_RST restarts the pulse count.
- infra_rst:
  - Registered. Drops to 0 the cycle after dly_ok=1, at least one count_valid has occurred since reset, and for every i, clk_alive[i] or not clk_req_mask[i].
  - Re-asserts the cycle after any condition fails, including rearm.
- Boundary cases:
  - Window edge and rdy drop in the same cycle are handled independently.
  - A mask change takes effect on the next cycle's evaluation.

Decomposition:
- Shared package infrastructure_pkg holds:
  - FSM state typedef (S_RST, S_WAIT, S_OK, S_FAIL).
  - Width helper constants for WIN_BITS and the timeout counter.
- One sub-module, clk_edge_counter: synchroniser, edge detect and saturating counter for one clock. It is instantiated NUM_CLK times and latched by the parent window logic.

Test Plan:
- sys_rst for 5 cycles, idelay_rdy=1 from start -> idelay_rst high for the 5 cycles plus 16 more. dly_ok=1 within 3 cycles after the pulse ends (2 sync flops + state register).
- idelay_rdy held 0 -> 4 S_RST pulses spaced 16+4096 cycles apart, retry_cnt steps 1,2,3, then dly_fail=1 with idelay_rst low. rearm -> retry_cnt=0, new pulse.
- clk_tick toggling every 4 sys_clk cycles, WIN_BITS=10 -> clk_count=256 (+/-1) each window, clk_alive=1. Stop the toggles -> next window count 0, alive=0, infra_rst=1.
- clk_req_mask=2'b01, clock 1 dead, clock 0 alive, dly_ok=1 -> infra_rst=0 the cycle after the first count_valid. Set mask=2'b11 -> infra_rst=1 next cycle.
- In S_OK, drop idelay_rdy for 1 cycle -> dly_ok=0, retry_cnt+1, new 16-cycle pulse, infra_rst asserted. rdy returns -> recovery.
- Tick toggling every cycle -> edge counter saturates at 1023 without wrap. rearm asserted together with sys_rst -> reset values, retry_cnt=0.
